// File: rtl/avmm_burst_memory.sv
// Avalon-MM slave memory model with fixed access latency, burst support,
// strict in-order completion through a timestamped request queue and sticky error flag.
module avmm_burst_memory #(
  parameter int unsigned DATA_WIDTH  = 512,
  parameter int unsigned ADDR_WIDTH  = 46,
  parameter int unsigned MEM_WORDS   = 4096,
  parameter int unsigned LATENCY     = 100,
  parameter int unsigned FIFO_DEPTH  = 64,
  parameter int unsigned READY_SLACK = 7,
  parameter int unsigned MAX_BURST   = 8,
  localparam int unsigned BC_W       = $clog2(MAX_BURST) + 1,
  localparam int unsigned BE_W       = DATA_WIDTH / 8,
  localparam int unsigned USE_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [BC_W-1:0]       burstcount,
  input  logic [BE_W-1:0]       byteenable,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  readdatavalid,
  output logic [USE_W-1:0]      usage,
  output logic                  proto_err
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [USE_W-1:0] READY_LVL = USE_W'(FIFO_DEPTH - READY_SLACK);
  localparam logic [USE_W-1:0] FULL_LVL  = USE_W'(FIFO_DEPTH);
  localparam logic [BC_W-1:0]  MAX_BC    = BC_W'(MAX_BURST);

  typedef enum logic {AccIdle, AccWburst} acc_st_e;
  typedef enum logic {CmpIdle, CmpRburst} cmp_st_e;

  typedef struct packed {
    logic                  is_write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [BC_W-1:0]       bc;
    logic [BE_W-1:0]       be;
    logic [DATA_WIDTH-1:0] data;
    logic [63:0]           ts;
  } entry_t;

  acc_st_e               acc_st_q, acc_st_d;
  cmp_st_e               cmp_st_q, cmp_st_d;
  logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
  logic [BC_W-1:0]       remaining_q, remaining_d;
  logic [BC_W-1:0]       beat_q, beat_d;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [USE_W-1:0]      usage_q;
  logic [63:0]           ts_q;
  logic                  proto_err_q, rdv_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  entry_t                fifo [FIFO_DEPTH];
  entry_t                push_entry, head;
  logic                  push, pop, err_set, mem_we, rd_en, full, eligible;
  logic [BC_W-1:0]       offset;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [IDX_W-1:0]      mem_idx;
  logic                  unused_addr_hi;
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  assign ready         = !rst && (usage_q < READY_LVL);
  assign full          = (usage_q == FULL_LVL);
  assign usage         = usage_q;
  assign proto_err     = proto_err_q;
  assign readdata      = rdata_q;
  assign readdatavalid = rdv_q;

  // Accept side: every dropped beat leaves state untouched and only raises the error flag.
  always_comb begin
    acc_st_d    = acc_st_q;
    next_addr_d = next_addr_q;
    remaining_d = remaining_q;
    push        = 1'b0;
    err_set     = 1'b0;
    push_entry  = '0;
    if (ready && (read || write)) begin
      if (read && write) begin
        err_set = 1'b1;
      end else if (full) begin
        err_set = 1'b1;
      end else if (acc_st_q == AccWburst) begin
        if (read) begin
          err_set = 1'b1;
        end else begin
          push                = 1'b1;
          push_entry.is_write = 1'b1;
          push_entry.addr     = next_addr_q;
          push_entry.bc       = BC_W'(1);
          push_entry.be       = byteenable;
          push_entry.data     = writedata;
          push_entry.ts       = ts_q;
          next_addr_d         = next_addr_q + ADDR_WIDTH'(1);
          remaining_d         = remaining_q - BC_W'(1);
          if (remaining_q == BC_W'(1)) acc_st_d = AccIdle;
        end
      end else if (burstcount == '0 || burstcount > MAX_BC) begin
        err_set = 1'b1;
      end else begin
        push                = 1'b1;
        push_entry.is_write = write;
        push_entry.addr     = address;
        push_entry.bc       = write ? BC_W'(1) : burstcount;
        push_entry.be       = byteenable;
        push_entry.data     = writedata;
        push_entry.ts       = ts_q;
        if (write) begin
          next_addr_d = address + ADDR_WIDTH'(1);
          remaining_d = burstcount - BC_W'(1);
          if (burstcount != BC_W'(1)) acc_st_d = AccWburst;
        end
      end
    end
  end

  // Completion side: the head stays in place for the whole read burst and is popped on its last beat.
  always_comb begin
    cmp_st_d = cmp_st_q;
    beat_d   = beat_q;
    pop      = 1'b0;
    mem_we   = 1'b0;
    rd_en    = 1'b0;
    offset   = '0;
    head     = fifo[rd_ptr_q];
    eligible = (usage_q != '0) && (head.ts + 64'(LATENCY) <= ts_q);
    case (cmp_st_q)
      CmpIdle: begin
        if (eligible) begin
          if (head.is_write) begin
            mem_we = 1'b1;
            pop    = 1'b1;
          end else begin
            rd_en = 1'b1;
            if (head.bc == BC_W'(1)) begin
              pop = 1'b1;
            end else begin
              cmp_st_d = CmpRburst;
              beat_d   = BC_W'(1);
            end
          end
        end
      end
      CmpRburst: begin
        rd_en  = 1'b1;
        offset = beat_q;
        if (beat_q == head.bc - BC_W'(1)) begin
          pop      = 1'b1;
          cmp_st_d = CmpIdle;
          beat_d   = '0;
        end else begin
          beat_d = beat_q + BC_W'(1);
        end
      end
    endcase
    mem_addr = head.addr + ADDR_WIDTH'(offset);
    mem_idx  = mem_addr[IDX_W-1:0];
  end

  assign unused_addr_hi = ^mem_addr[ADDR_WIDTH-1:IDX_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_st_q    <= AccIdle;
      cmp_st_q    <= CmpIdle;
      next_addr_q <= '0;
      remaining_q <= '0;
      beat_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      usage_q     <= '0;
      ts_q        <= '0;
      proto_err_q <= 1'b0;
      rdv_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      acc_st_q    <= acc_st_d;
      cmp_st_q    <= cmp_st_d;
      next_addr_q <= next_addr_d;
      remaining_q <= remaining_d;
      beat_q      <= beat_d;
      wr_ptr_q    <= wr_ptr_q + PTR_W'(push);
      rd_ptr_q    <= rd_ptr_q + PTR_W'(pop);
      usage_q     <= usage_q + USE_W'(push) - USE_W'(pop);
      ts_q        <= ts_q + 64'd1;
      proto_err_q <= proto_err_q | err_set;
      rdv_q       <= rd_en;
      if (rd_en) rdata_q <= mem[mem_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr_q] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < int'(BE_W); i++) begin
        if (head.be[i]) mem[mem_idx][8*i +: 8] <= head.data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_avmm_burst_memory.sv
// Directed bench for avmm_burst_memory at default parameters (LATENCY=100, MEM_WORDS=4096).
module tb_avmm_burst_memory;

  localparam int LAT = 100;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         read = 1'b0;
  logic         write = 1'b0;
  logic [45:0]  address = '0;
  logic [3:0]   burstcount = '0;
  logic [63:0]  byteenable = '0;
  logic [511:0] writedata = '0;
  logic         ready, readdatavalid, proto_err;
  logic [511:0] readdata;
  logic [6:0]   usage;

  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  logic [511:0] got_d[$];
  int           got_c[$];

  avmm_burst_memory dut (
    .clk           (clk),
    .rst           (rst),
    .read          (read),
    .write         (write),
    .address       (address),
    .burstcount    (burstcount),
    .byteenable    (byteenable),
    .writedata     (writedata),
    .ready         (ready),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .usage         (usage),
    .proto_err     (proto_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (readdatavalid) begin
      got_d.push_back(readdata);
      got_c.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] got_at(input int i);
    return (i < got_d.size()) ? got_d[i] : 'x;
  endfunction

  function automatic int cyc_at(input int i);
    return (i < got_c.size()) ? got_c[i] : -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic rd, input logic wr, input logic [45:0] a, input logic [3:0] bc,
                      input logic [63:0] be, input logic [511:0] d, output int acc_edge);
    read = rd; write = wr; address = a; burstcount = bc; byteenable = be; writedata = d;
    for (int i = 0; i < 500 && !ready; i++) tick();
    if (!ready) check("send_ready_timeout", 512'(ready), 512'(1));
    tick();
    acc_edge = cyc;
    read = 1'b0; write = 1'b0;
  endtask

  task automatic wait_n(input int n, input int limit);
    for (int i = 0; i < limit && got_d.size() < n; i++) tick();
    repeat (5) tick();
  endtask

  initial begin
    int k, kw, acc, fall;
    logic [511:0] aa;
    aa = {64{8'hAA}};

    // Reset state
    repeat (3) tick();
    check("rst_rdv", 512'(readdatavalid), 512'(0));
    check("rst_ready", 512'(ready), 512'(0));
    check("rst_usage", 512'(usage), 512'(0));
    check("rst_perr", 512'(proto_err), 512'(0));
    check("rst_rdata", readdata, 512'(0));
    rst = 1'b0;
    tick();
    check("ready_after_rst", 512'(ready), 512'(1));

    // Single read after a full-width write
    send(1'b0, 1'b1, 46'd5, 4'd1, '1, aa, k);
    got_d.delete(); got_c.delete();
    send(1'b1, 1'b0, 46'd5, 4'd1, '1, '0, k);
    wait_n(1, 150);
    check("t1_count", 512'(got_d.size()), 512'(1));
    check("t1_edge", 512'(cyc_at(0)), 512'(k + LAT));
    check("t1_data", got_at(0), aa);

    // Burst write with a partial byte lane on beat 2, then burst read
    send(1'b0, 1'b1, 46'd11, 4'd1, '1, '1, k);
    send(1'b0, 1'b1, 46'd10, 4'd4, '1, 512'd1, k);
    send(1'b0, 1'b1, 46'd0, 4'd0, 64'h1, 512'd2, k);
    send(1'b0, 1'b1, 46'd0, 4'd0, '1, 512'd3, k);
    send(1'b0, 1'b1, 46'd0, 4'd0, '1, 512'd4, k);
    got_d.delete(); got_c.delete();
    send(1'b1, 1'b0, 46'd10, 4'd4, '1, '0, k);
    wait_n(4, 150);
    check("t2_count", 512'(got_d.size()), 512'(4));
    check("t2_edge0", 512'(cyc_at(0)), 512'(k + LAT));
    check("t2_edge3", 512'(cyc_at(3)), 512'(k + LAT + 3));
    check("t2_beat0", got_at(0), 512'd1);
    check("t2_beat1", got_at(1), {{63{8'hFF}}, 8'h02});
    check("t2_beat2", got_at(2), 512'd3);
    check("t2_beat3", got_at(3), 512'd4);

    // Wrap at MEM_WORDS-1, two back-to-back reads
    send(1'b0, 1'b1, 46'd4095, 4'd3, '1, 512'hA, k);
    send(1'b0, 1'b1, 46'd0, 4'd0, '1, 512'hB, k);
    send(1'b0, 1'b1, 46'd0, 4'd0, '1, 512'hC, k);
    got_d.delete(); got_c.delete();
    send(1'b1, 1'b0, 46'd4095, 4'd3, '1, '0, k);
    send(1'b1, 1'b0, 46'd0, 4'd2, '1, '0, kw);
    wait_n(5, 150);
    check("t3_count", 512'(got_d.size()), 512'(5));
    check("t3_w0", got_at(0), 512'hA);
    check("t3_w1", got_at(1), 512'hB);
    check("t3_w2", got_at(2), 512'hC);
    check("t3_r0", got_at(3), 512'hB);
    check("t3_r1", got_at(4), 512'hC);
    check("t3_r0_edge", 512'(cyc_at(3)), 512'(k + LAT + 3));

    // Backpressure: 60 back-to-back single reads
    got_d.delete(); got_c.delete();
    read = 1'b1; write = 1'b0; address = 46'd5; burstcount = 4'd1;
    acc = 0; fall = -1;
    for (int i = 0; i < 2000 && acc < 60; i++) begin
      if (ready) acc++;
      else if (fall < 0) fall = int'(usage);
      tick();
    end
    read = 1'b0;
    check("t4_accepted", 512'(acc), 512'(60));
    check("t4_fall_usage", 512'(fall), 512'(57));
    wait_n(60, 400);
    check("t4_count", 512'(got_d.size()), 512'(60));
    check("t4_first", got_at(0), aa);
    check("t4_last", got_at(59), aa);
    check("t4_drained", 512'(usage), 512'(0));

    // Protocol errors
    check("t5_perr_before", 512'(proto_err), 512'(0));
    read = 1'b1; write = 1'b1; address = 46'd0; burstcount = 4'd1;
    tick();
    read = 1'b0; write = 1'b0;
    check("t5_perr_rw", 512'(proto_err), 512'(1));
    check("t5_usage_rw", 512'(usage), 512'(0));
    read = 1'b1; burstcount = 4'd0;
    tick();
    read = 1'b0;
    check("t5_usage_bc0", 512'(usage), 512'(0));
    read = 1'b1; burstcount = 4'd9;
    tick();
    read = 1'b0;
    check("t5_usage_bc9", 512'(usage), 512'(0));
    send(1'b0, 1'b1, 46'd20, 4'd2, '1, 512'h55, k);
    check("t5_usage_wb1", 512'(usage), 512'(1));
    read = 1'b1; address = 46'd20; burstcount = 4'd1;
    tick();
    read = 1'b0;
    check("t5_usage_rd_in_wburst", 512'(usage), 512'(1));
    send(1'b0, 1'b1, 46'd0, 4'd0, '1, 512'h66, k);
    check("t5_usage_wb2", 512'(usage), 512'(2));
    got_d.delete(); got_c.delete();
    send(1'b1, 1'b0, 46'd20, 4'd2, '1, '0, k);
    wait_n(2, 150);
    check("t5_rd0", got_at(0), 512'h55);
    check("t5_rd1", got_at(1), 512'h66);
    check("t5_perr_sticky", 512'(proto_err), 512'(1));

    // Reset during the second beat of an 8-beat read, with a write queued behind it
    got_d.delete(); got_c.delete();
    send(1'b1, 1'b0, 46'd10, 4'd8, '1, '0, k);
    send(1'b0, 1'b1, 46'd5, 4'd1, '1, 512'h77, kw);
    for (int i = 0; i < 300 && cyc < k + LAT + 1; i++) tick();
    check("t6_beat2_valid", 512'(readdatavalid), 512'(1));
    rst = 1'b1;
    #1;
    check("t6_rdv_drop", 512'(readdatavalid), 512'(0));
    check("t6_usage", 512'(usage), 512'(0));
    check("t6_ready", 512'(ready), 512'(0));
    tick();
    tick();
    check("t6_perr_cleared", 512'(proto_err), 512'(0));
    rst = 1'b0;
    tick();
    got_d.delete(); got_c.delete();
    send(1'b1, 1'b0, 46'd5, 4'd1, '1, '0, k);
    wait_n(1, 150);
    check("t6_count", 512'(got_d.size()), 512'(1));
    check("t6_edge", 512'(cyc_at(0)), 512'(k + LAT));
    check("t6_data", got_at(0), aa);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
